// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the set-associative cache controller.
package cache_pkg;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL_WAIT} state_t;

    function automatic int calc_off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int calc_idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int line_w, input int num_sets);
        return addr_w - calc_off_w(line_w) - calc_idx_w(num_sets);
    endfunction

    function automatic int calc_way_w(input int num_ways);
        return $clog2(num_ways);
    endfunction

    function automatic int calc_wsel_w(input int line_w, input int word_w);
        return $clog2(line_w / word_w);
    endfunction

endpackage

// File: rtl/cache_lru_tracker.sv
// Age-based LRU state per set: age 0 is most recent, age NUM_WAYS-1 is the replacement victim.
module cache_lru_tracker
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2,
    localparam int IDX_W = calc_idx_w(NUM_SETS),
    localparam int WAY_W = calc_way_w(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic [WAY_W-1:0] hit_way,
    input  logic             update,
    output logic [WAY_W-1:0] victim
);

    logic [WAY_W-1:0] age_q [NUM_SETS][NUM_WAYS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else if (update) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == hit_way)
                    age_q[idx][w] <= '0;
                else if (age_q[idx][w] < age_q[idx][hit_way])
                    age_q[idx][w] <= age_q[idx][w] + WAY_W'(1);
            end
        end
    end

    // Ages are a permutation, so exactly one way holds the oldest value.
    always_comb begin
        victim = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_q[idx][w] == WAY_W'(NUM_WAYS - 1))
                victim = WAY_W'(w);
        end
    end

endmodule

// File: rtl/set_assoc_cache_controller.sv
// N-way set-associative write-back / write-allocate cache between a CPU word port and a line memory.
module set_assoc_cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int WORD_W   = 32,
    parameter int LINE_W   = 128,
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [WORD_W-1:0] cpu_req_wdata,
    input  logic              cpu_req_rw,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    output logic [WORD_W-1:0] cpu_resp_data,
    output logic              cpu_resp_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    output logic              mem_req_rw,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    input  logic [LINE_W-1:0] mem_resp_data,
    input  logic              mem_resp_valid
);

    localparam int OFF_W  = calc_off_w(LINE_W);
    localparam int IDX_W  = calc_idx_w(NUM_SETS);
    localparam int TAG_W  = calc_tag_w(ADDR_W, LINE_W, NUM_SETS);
    localparam int WAY_W  = calc_way_w(NUM_WAYS);
    localparam int WSEL_W = calc_wsel_w(LINE_W, WORD_W);
    localparam int BSEL_W = OFF_W - WSEL_W;

    state_t              state;
    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [WSEL_W-1:0]   req_wsel;
    logic [WORD_W-1:0]   req_wdata;
    logic                req_rw;
    logic                lookup_done;
    logic                hit_p1;
    logic [WAY_W-1:0]    hit_way_p1;
    logic [WAY_W-1:0]    vic_way_p1;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];

    logic                hit_c;
    logic [WAY_W-1:0]    hit_way_c;
    logic                inv_found;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    vic_way_c;
    logic [WAY_W-1:0]    lru_victim;
    logic [WORD_W-1:0]   hit_word;
    logic                accept;
    logic                act;
    logic                lru_upd;
    logic                fill_we;
    logic                word_we;
    logic                unused_byte_sel;

    assign unused_byte_sel = ^cpu_req_addr[BSEL_W-1:0];
    assign accept  = (state == IDLE) && cpu_req_valid && cpu_req_ready;
    assign act     = (state == COMPARE) && lookup_done;
    assign lru_upd = act && hit_p1;
    assign word_we = act && hit_p1 && req_rw;
    assign fill_we = (state == FILL_WAIT) && mem_resp_valid;

    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag) && !hit_c) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!valid_q[req_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        vic_way_c = inv_found ? inv_way : lru_victim;
        hit_word  = data_q[req_idx][hit_way_p1][req_wsel*WORD_W +: WORD_W];
    end

    cache_lru_tracker #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_lru (
        .clk     (clk),
        .rst     (rst),
        .idx     (req_idx),
        .hit_way (hit_way_p1),
        .update  (lru_upd),
        .victim  (lru_victim)
    );

    // Request latch and line storage carry no reset; validity is tracked by valid_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_tag   <= cpu_req_addr[ADDR_W-1 -: TAG_W];
            req_idx   <= cpu_req_addr[OFF_W +: IDX_W];
            req_wsel  <= cpu_req_addr[BSEL_W +: WSEL_W];
            req_wdata <= cpu_req_wdata;
            req_rw    <= cpu_req_rw;
        end
        if (fill_we) begin
            data_q[req_idx][vic_way_p1] <= mem_resp_data;
            tag_q[req_idx][vic_way_p1]  <= req_tag;
        end
        if (word_we)
            data_q[req_idx][hit_way_p1][req_wsel*WORD_W +: WORD_W] <= req_wdata;
    end

    // COMPARE spends one cycle registering the lookup (_p1) and a second acting on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cpu_req_ready  <= 1'b1;
            cpu_resp_valid <= 1'b0;
            cpu_resp_data  <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_rw     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
            lookup_done    <= 1'b0;
            hit_p1         <= 1'b0;
            hit_way_p1     <= '0;
            vic_way_p1     <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            cpu_resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cpu_req_ready <= 1'b0;
                        lookup_done   <= 1'b0;
                        state         <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (!lookup_done) begin
                        hit_p1      <= hit_c;
                        hit_way_p1  <= hit_way_c;
                        vic_way_p1  <= vic_way_c;
                        lookup_done <= 1'b1;
                    end else begin
                        lookup_done <= 1'b0;
                        if (hit_p1) begin
                            cpu_resp_data  <= req_rw ? req_wdata : hit_word;
                            cpu_resp_valid <= 1'b1;
                            cpu_req_ready  <= 1'b1;
                            if (req_rw)
                                dirty_q[req_idx][hit_way_p1] <= 1'b1;
                            state <= IDLE;
                        end else if (valid_q[req_idx][vic_way_p1] && dirty_q[req_idx][vic_way_p1]) begin
                            mem_req_valid <= 1'b1;
                            mem_req_rw    <= 1'b1;
                            mem_req_addr  <= {tag_q[req_idx][vic_way_p1], req_idx, {OFF_W{1'b0}}};
                            mem_req_wdata <= data_q[req_idx][vic_way_p1];
                            state         <= WRITEBACK;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_req_rw    <= 1'b0;
                            mem_req_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                            state         <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_req_ready) begin
                        mem_req_rw   <= 1'b0;
                        mem_req_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        state        <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (mem_resp_valid) begin
                        valid_q[req_idx][vic_way_p1] <= 1'b1;
                        dirty_q[req_idx][vic_way_p1] <= 1'b0;
                        lookup_done                  <= 1'b0;
                        state                        <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/set_assoc_cache_controller.md
Name: set_assoc_cache_controller

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache controller; successor to the direct-mapped cache_controller.
- Sits between the CPU load/store port and the line-wide memory interface.
- Adds configurable sets, ways and line width, age-based LRU replacement, word-granular CPU writes, and a split memory request/response handshake.

Parameters:
- ADDR_W, 32, address width.
- WORD_W, 32, CPU data word width.
- LINE_W, 128, cache line width; multiple of WORD_W, power of two.
- NUM_SETS, 16, number of sets; power of two, ≥2.
- NUM_WAYS, 2, associativity; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req_addr  in  ADDR_W  byte address.
- cpu_req_wdata  in  WORD_W  write word.
- cpu_req_rw  in  1  1=write, 0=read.
- cpu_req_valid  in  1  request valid.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_resp_data  out  WORD_W  read data, or the written word for writes.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- mem_req_addr  out  ADDR_W  line-aligned address.
- mem_req_wdata  out  LINE_W  write-back line.
- mem_req_rw  out  1  1=write-back, 0=fill.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_data  in  LINE_W  fill line.
- mem_resp_valid  in  1  fill data valid.

Behaviour:
- Address split: OFF_W=log2(LINE_W/8); word select = addr[OFF_W-1:log2(WORD_W/8)]; index = next log2(NUM_SETS) bits; tag = the remaining upper bits.
- Storage is flop arrays: valid, dirty, tag and age per way/set, data per way/set. Reset clears valid, dirty and cpu_resp_data. Ages reset to the way number. Data is not reset.
- Reset values: cpu_req_ready=1, cpu_resp_valid=0, cpu_resp_data=0, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_wdata=0, state=IDLE.
- IDLE: cpu_req_ready=1. A request is accepted on cpu_req_valid & cpu_req_ready; addr, wdata and rw are latched; go to COMPARE. cpu_req_ready=0 in every other state.
- COMPARE, hit (one valid way matches the tag):
  - Read: cpu_resp_data = selected word.
  - Write: update that word, set dirty, cpu_resp_data = written word.
  - Pulse cpu_resp_valid (registered, high the cycle after COMPARE), update LRU, go to IDLE.
  - Hit latency: accept at edge N, cpu_resp_valid high between edges N+2 and N+3.
- COMPARE, miss, victim choice: the lowest-numbered invalid way; otherwise the way with maximum age.
  - Victim valid & dirty → WRITEBACK; otherwise → ALLOCATE.
- WRITEBACK: mem_req_valid=1, rw=1, addr={victim tag, index, 0}, wdata=victim line. All held stable until mem_req_ready is sampled high, then → ALLOCATE.
- ALLOCATE: mem_req_valid=1, rw=0, addr={req tag, index, 0}. On mem_req_ready → FILL_WAIT; mem_req_valid drops that edge.
- FILL_WAIT: on mem_resp_valid, write the line, tag=req tag, valid=1, dirty=0, → COMPARE. The re-compare is a guaranteed hit, and a write then merges and sets dirty.
- LRU update on every hit: the accessed way's age becomes 0; every way with age less than its old age increments. Ages stay a permutation of 0..NUM_WAYS-1.
- Ignored events:
  - mem_resp_valid outside FILL_WAIT.
  - mem_req_ready while mem_req_valid=0.
  - cpu_req_valid while not ready; the CPU must hold its request.
- Simultaneous events: mem_req_ready and mem_resp_valid in the same ALLOCATE cycle → the response is ignored; memory must return data no earlier than the cycle after acceptance.
- Reset mid-operation: abort immediately to IDLE, drop mem_req_valid, invalidate all lines. Dirty data is lost (documented behaviour).
- Back-to-back: a new request can be accepted the cycle after returning to IDLE, concurrent with cpu_resp_valid.

Decomposition:
- Package cache_pkg:
  - state enum {IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL_WAIT}.
  - Width-derivation functions for OFF_W, IDX_W, TAG_W, WAY_W, WSEL_W.
- Sub-module cache_lru_tracker(NUM_SETS, NUM_WAYS):
  - Owns the age arrays.
  - Inputs: set index, hit way, update strobe.
  - Output: victim way for the presented index.

Test Plan (defaults: index=addr[7:4], tag=addr[31:8], word select=addr[3:2]):
- Write 0xAB00 data 0x1122 after reset → miss, no write-back. Fill request at addr 0xAB00 rw=0; respond 0x0. cpu_resp_valid with 0x1122; set 0 way 0 becomes dirty.
- Read 0xAB00 → hit, no mem_req_valid. Response 0x1122 exactly 2 cycles after accept.
- Read 0xBB00 → miss, clean; way 1 is used. Respond fill 0x...3344 → cpu_resp_data=0x3344; no write-back.
- Read 0xEB00 → victim is LRU way 0. Write-back request addr 0xAB00 with word0=0x1122. mem_req_ready held low 3 cycles: request stays stable. Then fill at 0xEB00; respond 0x5566 → resp 0x5566.
- Read 0xBB04 → hit on way 1, returns word 1 of the 0x3344 line. Verify the LRU victim for set 0 is now the 0xEB way.
- Assert rst during FILL_WAIT → mem_req_valid=0, cpu_req_ready=1 next cycle. Read 0xBB00 → miss (lines invalidated).
